ahb_pipelined_master: RTL and testbench
=======================================

# ahb_pipelined_master

Parametrised AHB-Lite bus master for the AMBA bus test environment. It succeeds the single-register address/data forwarder with three additions: a command queue of configurable depth, a true pipelined address/data phase split with wait-state and two-cycle error handling, and a per-transfer response channel back to the testbench. It sits between the testbench command driver and one AHB-Lite slave or decoder.

## Interface
- ADDR_W, 32, HADDR and CMD_ADDR width
- DATA_W, 32, data width; 8, 16, 32 or 64; HSIZE = log2(DATA_W/8)
- DEPTH, 4, command FIFO entries; power of 2, at least 2
- HCLK  in  1  clock; all logic on the rising edge
- HRESET  in  1  asynchronous, active-high reset
- HADDR  out  ADDR_W  address-phase address
- HTRANS  out  2  2'b00 IDLE or 2'b10 NONSEQ only
- HWRITE  out  1  address-phase direction
- HSIZE  out  3  constant log2(DATA_W/8)
- HWDATA  out  DATA_W  data-phase write data
- HRDATA  in  DATA_W  slave read data
- HREADY  in  1  slave ready; low inserts a wait state
- HRESP  in  1  0 OKAY, 1 ERROR
- CMD_VALID  in  1  command offered
- CMD_READY  out  1  FIFO not full
- CMD_ADDR  in  ADDR_W  command address
- CMD_WDATA  in  DATA_W  command write data
- CMD_WRITE  in  1  1 write, 0 read
- RSP_VALID  out  1  one-cycle pulse per completed transfer
- RSP_RDATA  out  DATA_W  read data; 0 for writes
- RSP_ERR  out  1  transfer ended with ERROR
- BUSY  out  1  FIFO non-empty, or either bus phase occupied

## Operation
- FIFO: push on CMD_VALID & CMD_READY. CMD_READY = !full, computed from registered count; no push-through when full. Simultaneous push and pop are allowed when not full, and the count is unchanged.
- Address-phase register (AP: valid, addr, write, wdata). At any edge with HREADY=1, AP loads the FIFO head and pops it, or becomes invalid if the FIFO is empty.
  - HTRANS = NONSEQ when AP is valid, otherwise IDLE.
  - HADDR and HWRITE hold their last value while idle.
- Data-phase register (DP). At an edge with HREADY=1, DP takes AP. HWDATA = DP.wdata, held through waits.
- HREADY=0: AP, DP, HADDR, HTRANS, HWRITE and HWDATA are all frozen. The only exception is the error state below.
- Completion: a DP-valid edge with HREADY=1 produces a RSP_VALID pulse the next cycle.
  - RSP_RDATA = HRDATA for reads, 0 for writes.
  - RSP_ERR = HRESP.
- Error FSM, states NORMAL and ERR_CANCEL:
  - NORMAL -> ERR_CANCEL on an edge with DP valid, HRESP=1 and HREADY=0. The next cycle drives HTRANS=IDLE; AP contents are retained, not popped.
  - ERR_CANCEL -> NORMAL on the edge with HREADY=1. The errored response is issued, then AP re-issues as NONSEQ.
  - No command is lost or duplicated.
- HRESP=1 with HREADY=1 but no prior wait cycle: treated as an error response anyway, with no cancel.
- HREADY and HRESP are ignored while DP is invalid.
- No back-pressure on the response channel.

## Timing
- Reset state (asynchronous, immediate):
  - FIFO empty, AP and DP invalid, FSM in NORMAL.
  - HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0.
  - RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, BUSY=0, CMD_READY=1.
- Reset mid-transfer abandons all queued and in-flight commands; no response is produced.
- Zero-wait latency: a command pushed at edge N drives NONSEQ after N+1, is in data phase after N+2, and RSP_VALID is high in the cycle after N+3.
- Throughput: one transfer per cycle with a full queue and HREADY=1.
- Each wait cycle adds one cycle to that transfer and to everything behind it.
- Responses come back in command order.

## Test plan
- Single write, ADDR 0x4, DATA 0xDEADBEEF, zero-wait -> one NONSEQ cycle, HWDATA=0xDEADBEEF in the next cycle, RSP_VALID with RSP_ERR=0 and RSP_RDATA=0, BUSY then drops.
- Four back-to-back reads to 0x0, 0x4, 0x8, 0xC, slave returning addr+0x100 -> four consecutive NONSEQ cycles, four consecutive responses 0x100, 0x104, 0x108, 0x10C.
- Write to 0x8 with 2 wait states, followed by a read of 0xC -> HADDR=0xC, HTRANS and HWDATA stable across both waits; responses arrive 2 cycles late and in order.
- Fill DEPTH=4 with HREADY held low -> CMD_READY=0 after the queue is full; a push attempt is ignored; on HREADY=1 all queued commands complete in order.
- Error on a write to 0x10 (HRESP=1/HREADY=0, then HRESP=1/HREADY=1) with a read of 0x14 pending -> HTRANS=IDLE in the second cycle; RSP_ERR=1 for 0x10; 0x14 re-issues NONSEQ and completes with RSP_ERR=0.
- HRESET asserted while 3 commands are queued and one transfer is in data phase -> outputs go to reset values immediately; no RSP_VALID; CMD_READY=1 after release.

Source files
------------

// File: rtl/ahb_pipelined_master.sv
// AHB-Lite bus master: command FIFO feeding a split address/data pipeline,
// with wait-state freeze, two-cycle ERROR cancellation and a response pulse per transfer.
module ahb_pipelined_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              HCLK,
  input  logic              HRESET,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [DATA_W-1:0] CMD_WDATA,
  input  logic              CMD_WRITE,
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              RSP_ERR,
  output logic              BUSY
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef enum logic {ST_NORMAL, ST_ERR_CANCEL} state_t;

  cmd_t              fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ap_valid_q, ap_valid_d;
  cmd_t              ap_q, ap_d;
  logic              dp_valid_q, dp_valid_d;
  logic              dp_write_q, dp_write_d;
  logic [DATA_W-1:0] dp_wdata_q, dp_wdata_d;
  state_t            state_q, state_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic full, push, pop, complete;
  cmd_t cmd_in;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign push     = CMD_VALID && !full;
  assign complete = dp_valid_q && HREADY;
  assign cmd_in   = '{write: CMD_WRITE, addr: CMD_ADDR, wdata: CMD_WDATA};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d     = state_q;
    ap_valid_d  = ap_valid_q;
    ap_d        = ap_q;
    dp_valid_d  = dp_valid_q;
    dp_write_d  = dp_write_q;
    dp_wdata_d  = dp_wdata_q;
    rsp_valid_d = complete;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    pop         = 1'b0;

    unique case (state_q)
      ST_NORMAL: begin
        if (dp_valid_q && HRESP && !HREADY) begin
          state_d = ST_ERR_CANCEL;
        end else if (!dp_valid_q || HREADY) begin
          // Bus status is meaningless without a data phase, so an empty DP always advances.
          dp_valid_d = ap_valid_q;
          if (ap_valid_q) begin
            dp_write_d = ap_q.write;
            dp_wdata_d = ap_q.wdata;
          end
          if (count_q != '0) begin
            ap_valid_d = 1'b1;
            ap_d       = fifo_mem[rd_ptr_q];
            pop        = 1'b1;
          end else begin
            ap_valid_d = 1'b0;
          end
        end
      end
      ST_ERR_CANCEL: begin
        // The cancelled address phase stays in AP and re-issues once the error completes.
        if (HREADY) begin
          state_d    = ST_NORMAL;
          dp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_NORMAL;
    endcase

    if (complete) begin
      rsp_rdata_d = dp_write_q ? '0 : HRDATA;
      rsp_err_d   = HRESP;
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // NOTE: FIFO storage is not reset; only pointers and count need a known value.
  always_ff @(posedge HCLK) begin
    if (push) fifo_mem[wr_ptr_q] <= cmd_in;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ap_valid_q  <= 1'b0;
      ap_q        <= '0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_wdata_q  <= '0;
      state_q     <= ST_NORMAL;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ap_valid_q  <= ap_valid_d;
      ap_q        <= ap_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_wdata_q  <= dp_wdata_d;
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign HADDR     = ap_q.addr;
  assign HWRITE    = ap_q.write;
  assign HTRANS    = (ap_valid_q && state_q == ST_NORMAL) ? TRANS_NONSEQ : TRANS_IDLE;
  assign HSIZE     = 3'($clog2(DATA_W / 8));
  assign HWDATA    = dp_wdata_q;
  assign CMD_READY = !full;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign RSP_ERR   = rsp_err_q;
  assign BUSY      = (count_q != '0) || ap_valid_q || dp_valid_q;

endmodule

// File: tb/tb_ahb_pipelined_master.sv
// Directed bench for ahb_pipelined_master: a small AHB-Lite slave returns addr+0x100
// on reads; every check is an immediate assertion against a hand-derived value.
module tb_ahb_pipelined_master;

  logic        HCLK, HRESET;
  logic [31:0] HADDR, HWDATA, HRDATA, CMD_ADDR, CMD_WDATA, RSP_RDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE, HREADY, HRESP, CMD_VALID, CMD_READY, CMD_WRITE;
  logic        RSP_VALID, RSP_ERR, BUSY;

  int vectors = 0;
  int miscompares = 0;
  logic [32:0] rsp_q [$];

  ahb_pipelined_master #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_ADDR(CMD_ADDR),
    .CMD_WDATA(CMD_WDATA), .CMD_WRITE(CMD_WRITE), .RSP_VALID(RSP_VALID),
    .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .BUSY(BUSY)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Slave: captures an address phase whenever it has no stalled data phase pending.
  logic        slv_act;
  logic [31:0] slv_addr;
  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      slv_act  <= 1'b0;
      slv_addr <= '0;
    end else if (HREADY || !slv_act) begin
      slv_act  <= (HTRANS == 2'b10);
      slv_addr <= HADDR;
    end
  end
  assign HRDATA = slv_act ? slv_addr + 32'h100 : 32'h0;

  always @(negedge HCLK) begin
    if (RSP_VALID) rsp_q.push_back({RSP_ERR, RSP_RDATA});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((BUSY || RSP_VALID) && n < 40) begin
      step();
      n++;
    end
    chk(tag, 64'(n < 40), 64'd1);
  endtask

  initial begin
    HRESET = 1'b1; HREADY = 1'b1; HRESP = 1'b0;
    CMD_VALID = 1'b0; CMD_ADDR = '0; CMD_WDATA = '0; CMD_WRITE = 1'b0;

    // Reset state
    #12;
    chk("rst_htrans", HTRANS, 2'b00);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwrite", HWRITE, 1'b0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_rsp", {RSP_VALID, RSP_ERR, RSP_RDATA}, 34'h0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_cmd_ready", CMD_READY, 1'b1);
    chk("hsize", HSIZE, 3'd2);
    @(negedge HCLK);
    HRESET = 1'b0;
    step();

    // Single zero-wait write
    CMD_ADDR = 32'h4; CMD_WDATA = 32'hDEADBEEF; CMD_WRITE = 1'b1; CMD_VALID = 1'b1;
    step();
    CMD_VALID = 1'b0;
    chk("w1_queued_idle", HTRANS, 2'b00);
    chk("w1_busy", BUSY, 1'b1);
    step();
    chk("w1_nonseq", {HTRANS, HWRITE, HADDR}, {2'b10, 1'b1, 32'h4});
    step();
    chk("w1_dphase", {HTRANS, HWDATA}, {2'b00, 32'hDEADBEEF});
    chk("w1_no_rsp_yet", RSP_VALID, 1'b0);
    step();
    chk("w1_rsp", {RSP_VALID, RSP_ERR, RSP_RDATA}, {1'b1, 1'b0, 32'h0});
    chk("w1_busy_drop", BUSY, 1'b0);
    step();
    chk("w1_rsp_pulse", RSP_VALID, 1'b0);

    // Four back-to-back reads
    CMD_WRITE = 1'b0; CMD_WDATA = '0; CMD_VALID = 1'b1;
    CMD_ADDR = 32'h0; step();
    CMD_ADDR = 32'h4; step();
    chk("r4_a0", {HTRANS, HWRITE, HADDR}, {2'b10, 1'b0, 32'h0});
    CMD_ADDR = 32'h8; step();
    chk("r4_a1", {HTRANS, HADDR}, {2'b10, 32'h4});
    CMD_ADDR = 32'hC; step();
    chk("r4_a2", {HTRANS, HADDR}, {2'b10, 32'h8});
    chk("r4_rsp0", {RSP_VALID, RSP_ERR, RSP_RDATA}, {1'b1, 1'b0, 32'h100});
    CMD_VALID = 1'b0; step();
    chk("r4_a3", {HTRANS, HADDR}, {2'b10, 32'hC});
    chk("r4_rsp1", {RSP_VALID, RSP_RDATA}, {1'b1, 32'h104});
    step();
    chk("r4_idle", HTRANS, 2'b00);
    chk("r4_rsp2", {RSP_VALID, RSP_RDATA}, {1'b1, 32'h108});
    step();
    chk("r4_rsp3", {RSP_VALID, RSP_RDATA}, {1'b1, 32'h10C});
    step();
    chk("r4_done", {RSP_VALID, BUSY}, 2'b00);

    // Write with two wait states, then a read
    CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 32'h8; CMD_WDATA = 32'h11112222;
    step();
    CMD_WRITE = 1'b0; CMD_ADDR = 32'hC; CMD_WDATA = '0;
    step();
    CMD_VALID = 1'b0;
    chk("ws_w_nonseq", {HTRANS, HWRITE, HADDR}, {2'b10, 1'b1, 32'h8});
    step();
    chk("ws_r_nonseq", {HTRANS, HWRITE, HADDR}, {2'b10, 1'b0, 32'hC});
    HREADY = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("ws_hold%0d", i), {HTRANS, HADDR, HWDATA}, {2'b10, 32'hC, 32'h11112222});
      chk($sformatf("ws_norsp%0d", i), RSP_VALID, 1'b0);
    end
    HREADY = 1'b1;
    step();
    chk("ws_rsp_w", {RSP_VALID, RSP_ERR, RSP_RDATA}, {1'b1, 1'b0, 32'h0});
    step();
    chk("ws_rsp_r", {RSP_VALID, RSP_ERR, RSP_RDATA}, {1'b1, 1'b0, 32'h10C});
    drain("ws_drain");

    // Fill the queue while the slave stalls
    rsp_q.delete();
    HREADY = 1'b0; CMD_WRITE = 1'b0; CMD_VALID = 1'b1;
    for (int i = 0; i < 6; i++) begin
      CMD_ADDR = 32'h20 + 32'(4 * i);
      step();
      chk($sformatf("fill_ready%0d", i), CMD_READY, (i < 5) ? 1'b1 : 1'b0);
    end
    chk("fill_frozen", {HTRANS, HADDR}, {2'b10, 32'h24});
    CMD_ADDR = 32'h38;
    step();
    chk("fill_push_ignored", CMD_READY, 1'b0);
    CMD_VALID = 1'b0; HREADY = 1'b1;
    drain("fill_drain");
    chk("fill_rsp_count", rsp_q.size(), 6);
    for (int i = 0; i < 6 && i < rsp_q.size(); i++)
      chk($sformatf("fill_rsp%0d", i), rsp_q[i], {1'b0, 32'h120 + 32'(4 * i)});

    // Two-cycle error response on a write with a read pending
    rsp_q.delete();
    CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 32'h10; CMD_WDATA = 32'hAAAA5555;
    step();
    CMD_WRITE = 1'b0; CMD_ADDR = 32'h14; CMD_WDATA = '0;
    step();
    CMD_VALID = 1'b0;
    step();
    chk("err_r_nonseq", {HTRANS, HADDR}, {2'b10, 32'h14});
    HRESP = 1'b1; HREADY = 1'b0;
    step();
    chk("err_cancel_idle", {HTRANS, RSP_VALID}, {2'b00, 1'b0});
    HREADY = 1'b1;
    step();
    HRESP = 1'b0;
    chk("err_rsp", {RSP_VALID, RSP_ERR, RSP_RDATA}, {1'b1, 1'b1, 32'h0});
    chk("err_reissue", {HTRANS, HWRITE, HADDR}, {2'b10, 1'b0, 32'h14});
    step();
    chk("err_gap", {HTRANS, RSP_VALID}, {2'b00, 1'b0});
    step();
    chk("err_r_rsp", {RSP_VALID, RSP_ERR, RSP_RDATA}, {1'b1, 1'b0, 32'h114});
    drain("err_drain");
    chk("err_rsp_count", rsp_q.size(), 2);

    // Reset with commands queued and one in data phase
    HREADY = 1'b0; CMD_WRITE = 1'b1; CMD_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      CMD_ADDR = 32'h40 + 32'(4 * i);
      CMD_WDATA = 32'h5A5A0000 + 32'(i);
      step();
    end
    CMD_VALID = 1'b0;
    chk("rr_pre", {BUSY, CMD_READY, HWDATA}, {1'b1, 1'b1, 32'h5A5A0000});
    #2 HRESET = 1'b1;
    #1;
    chk("rr_async", {HTRANS, HADDR, HWRITE, HWDATA}, {2'b00, 32'h0, 1'b0, 32'h0});
    chk("rr_async_flags", {BUSY, CMD_READY, RSP_VALID}, {1'b0, 1'b1, 1'b0});
    HREADY = 1'b1;
    rsp_q.delete();
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    repeat (6) step();
    chk("rr_no_rsp", rsp_q.size(), 0);
    chk("rr_after", {BUSY, CMD_READY, HTRANS}, {1'b0, 1'b1, 2'b00});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
